// File: rtl/exu_flush_pkg.sv
// Shared definitions for the EXU flush-stall controller: depth codes,
// default update phase and source-index width helper.
package exu_flush_pkg;

    typedef enum int unsigned {
        FLUSH_NONE = 0,
        FLUSH_D1   = 1,
        FLUSH_D2   = 2
    } flush_depth_e;

    localparam int unsigned UPD_PHASE_DFLT = 4;

    // A single channel still needs a 1-bit source index.
    function automatic int unsigned src_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exu_flush_arb.sv
// Combinational flush arbiter: masks and clamps each channel's depth,
// then picks the deepest request, lowest channel index on ties.
module exu_flush_arb
    import exu_flush_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned DW        = 2,
    parameter int unsigned MAX_DEPTH = 3
) (
    input  logic [NCH*DW-1:0]      flush_req,
    input  logic [NCH-1:0]         flush_mask,
    output logic [DW-1:0]          req_max,
    output logic [src_w(NCH)-1:0]  winner
);

    localparam int unsigned SW = src_w(NCH);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

    logic [DW-1:0] eff;

    always_comb begin
        req_max = '0;
        winner  = '0;
        eff     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (flush_mask[i]) begin
                eff = '0;
            end else if (flush_req[i*DW +: DW] > MAX_D) begin
                eff = MAX_D;
            end else begin
                eff = flush_req[i*DW +: DW];
            end
            // Strictly greater keeps the lowest index among equal depths.
            if (eff > req_max) begin
                req_max = eff;
                winner  = SW'(i);
            end
        end
    end

endmodule

// File: rtl/exu_flush_ctrl.sv
// Flush-stall controller: slot counter updated on one cycle_cnt phase,
// registered stall outputs, winning source and saturating event counter.
module exu_flush_ctrl
    import exu_flush_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned DW        = 2,
    parameter int unsigned MAX_DEPTH = 3,
    parameter int unsigned CW        = 4,
    parameter int unsigned UPD_PHASE = UPD_PHASE_DFLT,
    parameter int unsigned PERF_W    = 16
) (
    input  logic                   hclk,
    input  logic                   hrst,
    input  logic [CW-1:0]          cycle_cnt,
    input  logic [NCH*DW-1:0]      flush_req,
    input  logic [NCH-1:0]         flush_mask,
    input  logic                   flush_clr,
    output logic                   flush_stall,
    output logic [DW-1:0]          stall_slots,
    output logic [src_w(NCH)-1:0]  flush_src,
    output logic                   flush_src_vld,
    output logic [PERF_W-1:0]      flush_evt_cnt
);

    localparam int unsigned SW = src_w(NCH);

    logic [DW-1:0] req_max;
    logic [SW-1:0] winner;
    logic [DW-1:0] dec;
    logic [DW-1:0] slots_n;
    logic          upd;
    logic          accept;

    exu_flush_arb #(
        .NCH       (NCH),
        .DW        (DW),
        .MAX_DEPTH (MAX_DEPTH)
    ) u_arb (
        .flush_req  (flush_req),
        .flush_mask (flush_mask),
        .req_max    (req_max),
        .winner     (winner)
    );

    // stall_slots doubles as the slot state; no separate shadow register.
    always_comb begin
        upd     = (cycle_cnt == CW'(UPD_PHASE));
        dec     = (stall_slots == '0) ? '0 : stall_slots - 1'b1;
        slots_n = stall_slots;
        accept  = 1'b0;
        if (flush_clr) begin
            slots_n = '0;
        end else if (upd) begin
            slots_n = (req_max > dec) ? req_max : dec;
            accept  = (req_max != '0) && (req_max > dec);
        end
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            stall_slots   <= '0;
            flush_stall   <= 1'b0;
            flush_src     <= '0;
            flush_src_vld <= 1'b0;
            flush_evt_cnt <= '0;
        end else begin
            stall_slots <= slots_n;
            flush_stall <= (slots_n != '0);
            if (flush_clr) begin
                flush_src_vld <= 1'b0;
            end else if (accept) begin
                flush_src     <= winner;
                flush_src_vld <= 1'b1;
                if (flush_evt_cnt != '1) begin
                    flush_evt_cnt <= flush_evt_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exu_flush_ctrl.sv
// Scoreboard bench for exu_flush_ctrl: two differently parametrised
// instances checked every cycle against a behavioural slot model.
module tb_exu_flush_ctrl;
    import exu_flush_pkg::*;

    typedef struct {
        int slots;
        int src;
        int vld;
        int cnt;
    } mst_t;

    typedef struct {
        mst_t a;
        mst_t b;
    } exp_t;

    logic       hclk = 1'b0;
    logic       hrst = 1'b1;
    logic [3:0] cycle_cnt = '0;
    logic [3:0] req_a = '0;
    logic [5:0] req_b = '0;
    logic [1:0] mask_a = '0;
    logic [2:0] mask_b = '0;
    logic       clr = 1'b0;

    logic       stall_a, vld_a, src_a;
    logic [1:0] slots_a;
    logic [2:0] cnt_a;
    logic       stall_b, vld_b;
    logic [1:0] slots_b, src_b, cnt_b;

    exp_t q[$];
    mst_t sa, sb;
    int   cc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 hclk = ~hclk;

    exu_flush_ctrl #(
        .NCH (2), .DW (2), .MAX_DEPTH (3), .CW (4), .UPD_PHASE (4), .PERF_W (3)
    ) dut_a (
        .hclk (hclk), .hrst (hrst), .cycle_cnt (cycle_cnt),
        .flush_req (req_a), .flush_mask (mask_a), .flush_clr (clr),
        .flush_stall (stall_a), .stall_slots (slots_a), .flush_src (src_a),
        .flush_src_vld (vld_a), .flush_evt_cnt (cnt_a)
    );

    exu_flush_ctrl #(
        .NCH (3), .DW (2), .MAX_DEPTH (2), .CW (4), .UPD_PHASE (9), .PERF_W (2)
    ) dut_b (
        .hclk (hclk), .hrst (hrst), .cycle_cnt (cycle_cnt),
        .flush_req (req_b), .flush_mask (mask_b), .flush_clr (clr),
        .flush_stall (stall_b), .stall_slots (slots_b), .flush_src (src_b),
        .flush_src_vld (vld_b), .flush_evt_cnt (cnt_b)
    );

    // Reference: remaining slots after an update is the larger of the
    // decremented count and the deepest live request.
    function automatic mst_t step(input mst_t s, input int nch, input int maxd,
                                  input int cmax, input int phase, input int ccv,
                                  input int req[3], input int mask,
                                  input bit c, input bit r);
        mst_t n = s;
        int   eff[3];
        int   rmax = 0;
        int   win = 0;
        int   rem;
        if (r) begin
            n = '{0, 0, 0, 0};
            return n;
        end
        for (int i = 0; i < nch; i++) begin
            eff[i] = ((mask >> i) & 1) ? 0 : ((req[i] > maxd) ? maxd : req[i]);
            if (eff[i] > rmax) rmax = eff[i];
        end
        for (int i = 0; i < nch; i++) begin
            if (eff[i] == rmax) begin
                win = i;
                break;
            end
        end
        rem = (s.slots > 0) ? s.slots - 1 : 0;
        if (c) begin
            n.slots = 0;
            n.vld   = 0;
        end else if (ccv == phase) begin
            if (rmax != 0 && rmax > rem) begin
                n.slots = rmax;
                n.src   = win;
                n.vld   = 1;
                n.cnt   = (s.cnt < cmax) ? s.cnt + 1 : s.cnt;
            end else begin
                n.slots = rem;
            end
        end
        return n;
    endfunction

    task automatic issue(input int a0, input int a1, input int b2,
                         input int mska, input int mskb, input bit c, input bit r);
        int rq[3];
        @(negedge hclk);
        rq = '{a0, a1, b2};
        cycle_cnt = 4'(cc);
        req_a     = {2'(a1), 2'(a0)};
        req_b     = {2'(b2), 2'(a1), 2'(a0)};
        mask_a    = 2'(mska);
        mask_b    = 3'(mskb);
        clr       = c;
        hrst      = r;
        sa = step(sa, 2, 3, 7, 4, cc, rq, mska, c, r);
        sb = step(sb, 3, 2, 3, 9, cc, rq, mskb, c, r);
        q.push_back('{sa, sb});
        cc = (cc + 1) % 16;
    endtask

    task automatic idle_to(input int p);
        while (cc != p) issue(0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic check(input string nm, input int st, input int sl, input int sr,
                         input int vl, input int cn, input mst_t e);
        int est = (e.slots != 0) ? 1 : 0;
        n_cmp++;
        if (st != est || sl != e.slots || sr != e.src || vl != e.vld || cn != e.cnt) begin
            n_err++;
            $display("FAIL %s @%0t: got stall=%0d slots=%0d src=%0d vld=%0d cnt=%0d, expected stall=%0d slots=%0d src=%0d vld=%0d cnt=%0d",
                     nm, $time, st, sl, sr, vl, cn, est, e.slots, e.src, e.vld, e.cnt);
        end
    endtask

    function automatic int rreq();
        return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge hclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("dut_a", int'(stall_a), int'(slots_a), int'(src_a),
                      int'(vld_a), int'(cnt_a), e.a);
                check("dut_b", int'(stall_b), int'(slots_b), int'(src_b),
                      int'(vld_b), int'(cnt_b), e.b);
            end
        end
    end

    initial begin : stimulus
        sa = '{0, 0, 0, 0};
        sb = '{0, 0, 0, 0};
        repeat (3) issue(0, 0, 0, 0, 0, 1'b0, 1'b1);
        repeat (16) issue(0, 0, 0, 0, 0, 1'b0, 1'b0);

        idle_to(4); issue(FLUSH_D2, 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (40) issue(0, 0, 0, 0, 0, 1'b0, 1'b0);

        idle_to(4); issue(FLUSH_D1, 3, 0, 0, 0, 1'b0, 1'b0);
        idle_to(4); issue(FLUSH_D2, FLUSH_D2, 0, 0, 0, 1'b0, 1'b0);
        repeat (50) issue(0, 0, 0, 0, 0, 1'b0, 1'b0);
        idle_to(4); issue(0, 3, 0, 2, 2, 1'b0, 1'b0);

        idle_to(4); issue(3, 0, 0, 0, 0, 1'b0, 1'b0);
        idle_to(4); issue(FLUSH_D1, 0, 0, 0, 0, 1'b0, 1'b0);
        idle_to(4); issue(3, 0, 0, 0, 0, 1'b0, 1'b0);
        idle_to(2); issue(3, 3, 3, 0, 0, 1'b1, 1'b0);
        issue(0, 0, 0, 0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 9; k++) begin
            idle_to(4); issue(FLUSH_D1, 0, FLUSH_D1, 0, 0, 1'b0, 1'b0);
        end
        idle_to(9); issue(0, 0, FLUSH_D2, 0, 0, 1'b0, 1'b0);
        idle_to(4); issue(FLUSH_D2, 0, 0, 0, 0, 1'b0, 1'b0);
        issue(0, 0, 0, 0, 0, 1'b0, 1'b0);
        issue(0, 0, 0, 0, 0, 1'b0, 1'b1);
        repeat (4) issue(0, 0, 0, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) cc = int'($urandom_range(0, 15));
            issue(rreq(), rreq(), rreq(),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 299) == 0);
        end

        repeat (3) @(posedge hclk);
        #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exu_flush_ctrl.md
Name: exu_flush_ctrl

Overview:
Parametrised flush-stall controller for the execution unit. It generalises the two-level flush stall FSM into a slot counter of configurable depth, fed by NCH independent flush sources. Sources can be masked. The block reports which source won arbitration, supports an immediate flush abort, and keeps a saturating count of accepted flush events. It sits between the EXU flush generators (branch, trap, fence) and the fetch/decode stall logic, and is phase-aligned to the shared cycle_cnt.

Parameters:
NCH, 2, number of flush request channels (>=1)
DW, 2, width of each per-channel depth request and of the slot counter
MAX_DEPTH, 3, largest stall depth in slots; requests above it are clamped (MAX_DEPTH <= 2**DW-1)
CW, 4, width of cycle_cnt
UPD_PHASE, 4, cycle_cnt value on which the slot counter updates
PERF_W, 16, width of the flush event counter

Ports:
hclk  in  1  clock
hrst  in  1  synchronous, active-high reset
cycle_cnt  in  CW  shared pipeline phase counter
flush_req  in  NCH*DW  per-channel requested depth; channel i occupies bits [i*DW +: DW]; 0 = no flush
flush_mask  in  NCH  1 = channel i ignored
flush_clr  in  1  abort: drop all pending stall slots
flush_stall  out  1  registered stall to front end
stall_slots  out  DW  registered remaining stall slots
flush_src  out  max(1,$clog2(NCH))  index of the channel that last set the slot counter
flush_src_vld  out  1  flush_src is meaningful (at least one accept since reset or clear)
flush_evt_cnt  out  PERF_W  saturating count of accepted flush requests

Behaviour:
- Reset: hrst is sampled on posedge hclk. While hrst=1 on a clock edge, every output and the internal state go to 0. Reset mid-stall drops all pending slots. The first cycle after reset behaves as idle.
- Per-channel effective depth: eff_i = 0 if flush_mask[i], else min(flush_req_i, MAX_DEPTH).
- Arbitration (combinational): req_max = max(eff_i). The winner is the lowest index among channels whose eff_i equals req_max.
- upd = (cycle_cnt == UPD_PHASE).
- dec = (slots == 0) ? 0 : slots - 1.
- Next slot count, in priority order:
  - flush_clr = 1: slots_n = 0. This applies in any phase and overrides simultaneous requests.
  - else if upd: slots_n = max(dec, req_max).
  - else: slots_n = slots (hold).
- accept = upd & !flush_clr & (req_max != 0) & (req_max > dec).
- A request that does not exceed the remaining decremented slots is absorbed: no accept, and flush_src is unchanged.
- On accept:
  - flush_src <= winner
  - flush_src_vld <= 1
  - flush_evt_cnt increments by 1 and saturates at all-ones.
- flush_clr sets flush_src_vld <= 0 and leaves flush_src and flush_evt_cnt unchanged.
- Registered outputs: stall_slots <= slots_n and flush_stall <= (slots_n != 0). Both are valid in the cycle after the deciding edge, with the same latency as the slot state.
- Depth semantics: a depth-d request accepted at update phase keeps flush_stall high through d update phases. It falls at the d-th subsequent update with no further request. Between updates it holds.
- Compatibility: with NCH=1, MAX_DEPTH=2, UPD_PHASE=4, a depth 1/2 request reproduces flush-cycle-1/2 stalling. One deliberate difference: a depth-1 request in the last pending slot re-arms one slot; it is not ignored.
- Equal-depth requests on several channels count as one event.
- cycle_cnt values above UPD_PHASE, or wrap-around of cycle_cnt, have no special meaning.

Decomposition:
- Shared package exu_flush_pkg holds:
  - depth constants FLUSH_NONE=0, FLUSH_D1=1, FLUSH_D2=2
  - default UPD_PHASE
  - the helper function for src index width
- One sub-module, exu_flush_arb: purely combinational mask/clamp/max/lowest-index arbiter. Parameters NCH, DW, MAX_DEPTH. Outputs req_max and winner.
- Slot counter, output registers and perf counter live in exu_flush_ctrl.

Test Plan:
- Reset/idle: hrst high 3 cycles, then cycle_cnt sweeps 0..15 with flush_req=0 -> all outputs stay 0.
- Depth 2 on ch0 at cycle_cnt=4 -> next cycle flush_stall=1, stall_slots=2, flush_src=0, flush_evt_cnt=1. Then stall_slots=1 after the next phase-4 edge, 0 after the one after. flush_stall drops with it.
- Arbitration: ch0=1, ch1=3 (MAX_DEPTH=3) at phase 4 -> stall_slots=3, flush_src=1. Repeat with ch0=ch1=2 -> flush_src=0 and the counter increments once. With flush_mask=2'b10 and ch1=3, ch0=0 -> no stall.
- Absorb/extend: with slots=3, depth-1 request at phase 4 -> slots 2, no accept. Then a depth-3 request -> slots 3, accept. A request of 3 on a DW=2 clamp with MAX_DEPTH=2 -> slots 2.
- Clear: slots=3, flush_clr=1 at cycle_cnt=2 together with a depth-3 request -> next cycle flush_stall=0, stall_slots=0, flush_src_vld=0, counter unchanged.
- Saturation/reset mid-op: PERF_W=2, five accepts -> flush_evt_cnt stays 3. Assert hrst while slots=2 -> all outputs 0 on the next cycle.
